mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Parametrised, elastic MEM->WB pipeline register; successor to the single-stage, single-lane MEM/WB latch.
- Adds configurable depth (STAGES) and multi-issue lanes (LANES).
- Adds valid/ready backpressure, synchronous flush, x0 write suppression, and same-stage lane-collision masking.
- Provides a forwarding lookup port so decode/execute can bypass values still in flight to the regfile.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- LANES, 1, write lanes per entry (1..4).
- STAGES, 1, pipeline depth between MEM and regfile (1..4).
- NQ, 2, number of forwarding query ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush of all in-flight entries.
- in_valid_i  in  1  MEM presents an entry.
- in_ready_o  out  1  pipe accepts the entry this cycle.
- rd_we_i  in  LANES  per-lane write enable.
- rd_addr_i  in  LANES*ADDR_W  per-lane destination; lane l is at [l*ADDR_W +: ADDR_W].
- rd_data_i  in  LANES*DATA_W  per-lane write data.
- out_valid_o  out  1  last stage holds a valid entry.
- out_ready_i  in  1  regfile/WB consumes the entry.
- rd_we_o  out  LANES  per-lane write enable to regfile; already masked.
- rd_addr_o  out  LANES*ADDR_W  per-lane destination to regfile.
- rd_data_o  out  LANES*DATA_W  per-lane write data to regfile.
- q_addr_i  in  NQ*ADDR_W  forwarding query addresses.
- q_hit_o  out  NQ  query matched an in-flight write.
- q_data_o  out  NQ*DATA_W  forwarded data; 0 when there is no hit.

Behaviour:
- State per stage k (0 = youngest, STAGES-1 = output): v[k], we[k][LANES], addr[k], data[k].
- Reset (async, rst=1): all v and we are 0, all addr and data are 0.
  - out_valid_o=0, rd_we_o=0, rd_addr_o=0, rd_data_o=0, q_hit_o=0, q_data_o=0.
  - in_ready_o=1 while in reset.
- Ready chain, combinational:
  - rdy[STAGES] = out_ready_i.
  - rdy[k] = !v[k] | rdy[k+1].
  - in_ready_o = rdy[0] | flush_i.
- Advance, per stage, on each clk edge when rdy[k]=1:
  - stage k loads stage k-1 contents (v, we, addr, data).
  - stage 0 loads v=in_valid_i and the input entry.
  - When rdy[k]=0, stage k holds all of its fields.
- Capture gating into stage 0: we[0][l] = rd_we_i[l] & in_valid_i & (rd_addr_i lane l != 0).
  - A write to x0 never leaves the block.
  - A valid entry with all we=0 (e.g. store or branch) still occupies a slot and still asserts out_valid_o.
- Latency: with no backpressure, an entry accepted at edge N appears on the outputs after edge N+STAGES-1, i.e. during the cycle following that edge.
  - STAGES=1 gives the original one-cycle MEM/WB latency.
  - Full throughput is one entry per cycle.
- Flush: flush_i=1 at an edge clears every v and we; data and addr are don't-care.
  - Flush has priority over load and hold.
  - An input presented in the same cycle as flush is handshaken (in_ready_o=1) and discarded.
  - On the cycle after flush, out_valid_o=0.
- Output: out_valid_o = v[STAGES-1]; rd_addr_o and rd_data_o come directly from the last stage.
  - rd_we_o[l] = v & we[l] & !(any higher lane h>l in the same stage has we[h] and addr[h]==addr[l]).
  - Within an entry, the higher lane is later in program order, so the regfile receives at most one write per address per cycle.
  - The regfile must assert out_ready_i whenever it can retire. If out_ready_i=0, the last stage holds and rd_we_o remains asserted; the regfile must ignore it unless out_ready_i=1, so the write is qualified by out_valid_o & out_ready_i.
- Forwarding, combinational from registered state:
  - For query j, scan stages youngest to oldest (0..STAGES-1); within a stage scan lanes highest to lowest.
  - The first entry with v & we & addr==q_addr_j wins: q_hit_o[j]=1 and q_data_o[j] = its data.
  - q_addr_j == 0 never hits.
  - The incoming rd_*_i entry is not searched; that bypass belongs to the MEM stage.
- Reset asserted mid-operation: state clears immediately (async), without waiting for a clock edge. Deassertion is synchronised externally.

Test Plan:
- Reset, then STAGES=2, LANES=1, out_ready_i=1. Push {we=1, addr=5, data=0xDEADBEEF} at edge 0 -> out_valid_o=1 and rd_we_o=1, addr=5, data=0xDEADBEEF during the cycle after edge 1; out_valid_o=0 one cycle later.
- STAGES=2, out_ready_i=0, push 3 entries (A, B, C) -> A and B are accepted, in_ready_o drops to 0 while C is held by MEM. Raise out_ready_i -> outputs are A, B, C on consecutive cycles, none lost or duplicated.
- Push addr=0 with we=1 and data=0x1234 -> out_valid_o=1 and rd_we_o=0. Query q_addr=0 -> q_hit_o=0.
- STAGES=3 holding writes to x7 in stage 2 (data 0x11) and stage 0 (data 0x22) -> query x7 gives hit=1 and data=0x22. Query x8 gives hit=0 and data=0.
- LANES=2, single entry with both lanes writing x9 (lane0=0xAA, lane1=0xBB) -> rd_we_o=2'b10 at the output. Query x9 returns 0xBB.
- Pipe full with out_ready_i=0, then flush_i=1 for one cycle together with in_valid_i=1 -> next cycle out_valid_o=0 and all q_hit_o=0. The flushed input never appears on the outputs.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// Elastic MEM->WB pipeline: STAGES deep, LANES writes per entry, valid/ready
// backpressure, flush, x0 suppression, lane-collision masking and forwarding lookup.

// Lane write enable at the regfile side: a lane is shadowed when a higher
// (program-order later) lane of the same entry writes the same register.
module mem_wb_lane_mask #(
  parameter int LANES  = 1,
  parameter int ADDR_W = 5,
  parameter int LANE   = 0
) (
  input  logic                      v,
  input  logic [LANES-1:0]          we,
  input  logic [LANES*ADDR_W-1:0]   addr,
  output logic                      we_out
);
  logic shadow;

  always_comb begin
    shadow = 1'b0;
    for (int h = LANE + 1; h < LANES; h++)
      if (we[h] && addr[h*ADDR_W +: ADDR_W] == addr[LANE*ADDR_W +: ADDR_W])
        shadow = 1'b1;
  end

  assign we_out = v & we[LANE] & ~shadow;
endmodule

module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int STAGES = 1,
  parameter int NQ     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES-1:0]         rd_we_i,
  input  logic [LANES*ADDR_W-1:0]  rd_addr_i,
  input  logic [LANES*DATA_W-1:0]  rd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES-1:0]         rd_we_o,
  output logic [LANES*ADDR_W-1:0]  rd_addr_o,
  output logic [LANES*DATA_W-1:0]  rd_data_o,
  input  logic [NQ*ADDR_W-1:0]     q_addr_i,
  output logic [NQ-1:0]            q_hit_o,
  output logic [NQ*DATA_W-1:0]     q_data_o
);
  logic [STAGES-1:0]                    v;
  logic [STAGES-1:0][LANES-1:0]         we;
  logic [STAGES-1:0][LANES*ADDR_W-1:0]  addr;
  logic [STAGES-1:0][LANES*DATA_W-1:0]  data;
  logic [STAGES-1:0]                    rdy;
  logic [LANES-1:0]                     we_in;

  // Stage k may advance if the output drains or any bubble sits at or below it;
  // accumulated from the output end so the chain has no self-dependency.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready_i;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc | ~v[k];
      rdy[k] = acc;
    end
  end

  assign in_ready_o = rdy[0] | flush_i;

  for (genvar l = 0; l < LANES; l++) begin : g_cap
    assign we_in[l] = rd_we_i[l] & in_valid_i & (rd_addr_i[l*ADDR_W +: ADDR_W] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v    <= '0;
      we   <= '0;
      addr <= '0;
      data <= '0;
    end else if (flush_i) begin
      v  <= '0;
      we <= '0;
    end else begin
      if (rdy[0]) begin
        v[0]    <= in_valid_i;
        we[0]   <= we_in;
        addr[0] <= rd_addr_i;
        data[0] <= rd_data_i;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k]    <= v[k-1];
          we[k]   <= we[k-1];
          addr[k] <= addr[k-1];
          data[k] <= data[k-1];
        end
      end
    end
  end

  assign out_valid_o = v[STAGES-1];
  assign rd_addr_o   = addr[STAGES-1];
  assign rd_data_o   = data[STAGES-1];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mem_wb_lane_mask #(.LANES(LANES), .ADDR_W(ADDR_W), .LANE(l)) u_mask (
      .v      (v[STAGES-1]),
      .we     (we[STAGES-1]),
      .addr   (addr[STAGES-1]),
      .we_out (rd_we_o[l])
    );
  end

  // Oldest-to-youngest, lowest-to-highest lane: the last match assigned wins,
  // giving youngest stage / highest lane priority.
  always_comb begin
    q_hit_o  = '0;
    q_data_o = '0;
    for (int j = 0; j < NQ; j++)
      for (int k = STAGES - 1; k >= 0; k--)
        for (int l = 0; l < LANES; l++)
          if (v[k] && we[k][l] && q_addr_i[j*ADDR_W +: ADDR_W] != '0 &&
              addr[k][l*ADDR_W +: ADDR_W] == q_addr_i[j*ADDR_W +: ADDR_W]) begin
            q_hit_o[j]                  = 1'b1;
            q_data_o[j*DATA_W +: DATA_W] = data[k][l*DATA_W +: DATA_W];
          end
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed + random bench for mem_wb_pipe (STAGES=3, LANES=2) against a slot
// model with an in-order retirement scoreboard.
module tb_mem_wb_pipe;
  localparam int DW = 32, AW = 5, L = 2, S = 3, NQ = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [L-1:0]     rd_we_i, rd_we_o;
  logic [L*AW-1:0]  rd_addr_i, rd_addr_o;
  logic [L*DW-1:0]  rd_data_i, rd_data_o;
  logic [NQ*AW-1:0] q_addr_i;
  logic [NQ-1:0]    q_hit_o;
  logic [NQ*DW-1:0] q_data_o;

  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .STAGES(S), .NQ(NQ)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .q_addr_i(q_addr_i), .q_hit_o(q_hit_o), .q_data_o(q_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    bit [L-1:0]    we;
    bit [L*AW-1:0] addr;
    bit [L*DW-1:0] data;
  } ent_t;

  ent_t          m[S];
  bit [L*DW-1:0] sbq[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < S; k++) m[k] = '{default: '0};
    sbq.delete();
  endtask

  // Drive one cycle of inputs, compare every output against the model, then clock.
  task automatic step(input bit iv, input bit [L-1:0] w, input bit [L*AW-1:0] a,
                      input bit [L*DW-1:0] d, input bit ordy, input bit fl,
                      input bit [NQ*AW-1:0] qa);
    int top;
    bit [L-1:0] ew;
    bit [NQ-1:0] eh;
    bit [NQ*DW-1:0] ed;
    bit done;
    in_valid_i = iv; rd_we_i = w; rd_addr_i = a; rd_data_i = d;
    out_ready_i = ordy; flush_i = fl; q_addr_i = qa;
    #1;
    // Highest stage that may move: everything at or below the topmost bubble shifts.
    top = -1;
    if (ordy) top = S - 1;
    else for (int k = S - 1; k >= 0; k--) if (!m[k].v && top < 0) top = k;
    chk("in_ready", in_ready_o, (top >= 0) || fl);
    chk("out_valid", out_valid_o, m[S-1].v);
    for (int l = 0; l < L; l++) begin
      bit later = 0;
      for (int h = l + 1; h < L; h++)
        if (m[S-1].we[h] && m[S-1].addr[h*AW +: AW] == m[S-1].addr[l*AW +: AW]) later = 1;
      ew[l] = m[S-1].v && m[S-1].we[l] && !later;
    end
    chk("rd_we", rd_we_o, ew);
    if (m[S-1].v) begin
      chk("rd_addr", rd_addr_o, m[S-1].addr);
      chk("rd_data", rd_data_o, m[S-1].data);
    end
    eh = '0; ed = '0;
    for (int j = 0; j < NQ; j++) begin
      done = 0;
      for (int k = 0; k < S; k++)
        for (int l = L - 1; l >= 0; l--)
          if (!done && qa[j*AW +: AW] != 0 && m[k].v && m[k].we[l] &&
              m[k].addr[l*AW +: AW] == qa[j*AW +: AW]) begin
            eh[j] = 1; ed[j*DW +: DW] = m[k].data[l*DW +: DW]; done = 1;
          end
    end
    chk("q_hit", q_hit_o, eh);
    chk("q_data", q_data_o, ed);
    if (out_valid_o && ordy && sbq.size() > 0) begin
      chk("retire_order", rd_data_o, sbq[0]);
      void'(sbq.pop_front());
    end
    if (fl) sbq.delete();
    else if (iv && top >= 0) sbq.push_back(d);
    if (fl) begin
      for (int k = 0; k < S; k++) begin m[k].v = 0; m[k].we = '0; end
    end else if (top >= 0) begin
      for (int k = top; k >= 1; k--) m[k] = m[k-1];
      m[0].v = iv;
      for (int l = 0; l < L; l++) m[0].we[l] = w[l] && iv && (a[l*AW +: AW] != 0);
      m[0].addr = a;
      m[0].data = d;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, '0, '0, '0, ordy, 0, '0);
  endtask

  initial begin
    bit [L*AW-1:0] ra;
    bit [L*DW-1:0] rdat;
    bit [NQ*AW-1:0] rq;
    rst = 1; flush_i = 0; in_valid_i = 0; rd_we_i = '0; rd_addr_i = '0;
    rd_data_i = '0; out_ready_i = 1; q_addr_i = {5'd7, 5'd5};
    model_clear();
    #2;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_rd_we", rd_we_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_q_hit", q_hit_o, 0);
    chk("rst_q_data", q_data_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    @(posedge clk); #1; rst = 0;

    // Latency S-1 edges after acceptance, then gone.
    step(1, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 1, 0, '0);
    idle(1); idle(1);
    chk("lat_valid", out_valid_o, 1);
    chk("lat_we", rd_we_o, 2'b01);
    chk("lat_addr", rd_addr_o[AW-1:0], 5);
    chk("lat_data", rd_data_o[DW-1:0], 32'hDEADBEEF);
    idle(1);
    chk("lat_gone", out_valid_o, 0);

    // Backpressure: three fit, fourth is held by MEM until the output drains.
    step(1, 2'b01, {5'd0, 5'd1}, {32'd0, 32'hA}, 0, 0, '0);
    step(1, 2'b01, {5'd0, 5'd2}, {32'd0, 32'hB}, 0, 0, '0);
    step(1, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hC}, 0, 0, '0);
    chk("bp_full", in_ready_o, 0);
    step(1, 2'b01, {5'd0, 5'd4}, {32'd0, 32'hD}, 0, 0, '0);
    step(1, 2'b01, {5'd0, 5'd4}, {32'd0, 32'hD}, 1, 0, '0);
    repeat (4) idle(1);
    chk("bp_drained", sbq.size(), 0);

    // x0 write: slot occupied, no write, no forwarding hit.
    step(1, 2'b01, {5'd0, 5'd0}, {32'd0, 32'h1234}, 1, 0, '0);
    q_addr_i = '0; #1;
    chk("x0_q_hit", q_hit_o, 0);
    idle(1); idle(1);
    chk("x0_valid", out_valid_o, 1);
    chk("x0_we", rd_we_o, 0);
    idle(1);

    // Forwarding priority: youngest stage wins.
    step(1, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h11}, 0, 0, '0);
    step(1, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h33}, 0, 0, '0);
    step(1, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h22}, 0, 0, '0);
    q_addr_i = {5'd8, 5'd7}; #1;
    chk("fwd_hit", q_hit_o, 2'b01);
    chk("fwd_data7", q_data_o[DW-1:0], 32'h22);
    chk("fwd_data8", q_data_o[2*DW-1:DW], 0);

    // Flush of a full pipe together with an input that must vanish.
    step(1, 2'b01, {5'd0, 5'd6}, {32'd0, 32'h66}, 0, 1, {5'd6, 5'd7});
    q_addr_i = {5'd6, 5'd7}; #1;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_q_hit", q_hit_o, 0);
    repeat (3) idle(1);

    // Same-entry collision: higher lane wins at regfile and in forwarding.
    step(1, 2'b11, {5'd9, 5'd9}, {32'hBB, 32'hAA}, 1, 0, '0);
    q_addr_i = {5'd0, 5'd9}; #1;
    chk("col_q_hit", q_hit_o, 2'b01);
    chk("col_q_data", q_data_o[DW-1:0], 32'hBB);
    idle(1); idle(1);
    chk("col_we", rd_we_o, 2'b10);
    idle(1);

    // Random traffic with small address space for collisions and hits.
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < L; l++) begin
        ra[l*AW +: AW] = AW'($urandom_range(0, 7));
        rdat[l*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NQ; j++) rq[j*AW +: AW] = AW'($urandom_range(0, 7));
      step(($urandom % 4) != 0, L'($urandom), ra, rdat, ($urandom % 10) < 7,
           ($urandom % 20) == 0, rq);
    end

    // Asynchronous reset mid-operation.
    repeat (3) step(1, 2'b11, {5'd4, 5'd5}, {32'h44, 32'h55}, 0, 0, '0);
    q_addr_i = {5'd4, 5'd5};
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_q_hit", q_hit_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    model_clear();
    @(posedge clk); #1; rst = 0;
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
